pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
//  Replaces the fixed-field EX/MEM and MEM/WB latches: one generic block, payload packed by caller.
//  Adds per-stage back-pressure (stall), synchronous flush, and bubble zeroing.
//  Adds a saturating stall counter for CPI profiling.
//  Full throughput: one transfer per cycle when downstream is ready.
// PARAMETERS
//  WIDTH             72  payload width in bits (packed control + data fields)
//  CLEAR_ON_BUBBLE   1   1: out_data forced to 0 whenever out_valid=0; 0: hold last value
//  CNT_W             16  width of stall_cnt / flush_cnt
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-low reset
//  flush      in   1        synchronous kill of all held entries (branch/exception)
//  in_valid   in   1        upstream payload valid
//  in_data    in   WIDTH    upstream payload
//  in_ready   out  1        stage can accept this cycle (= !skid_valid, registered source)
//  out_valid  out  1        stage holds a valid payload (= main_valid)
//  out_data   out  WIDTH    payload to next stage (= main_data)
//  out_ready  in   1        downstream accepts this cycle
//  stall_cnt  out  CNT_W    cycles with out_valid=1 & out_ready=0, saturating
//  flush_cnt  out  CNT_W    entries discarded by flush (0/1/2 per flush), saturating
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset (reset=0, async): main_valid=0, skid_valid=0, main_data=0, skid_data=0,
//    stall_cnt=0, flush_cnt=0 -> out_valid=0, out_data=0, in_ready=1. in_valid ignored while reset=0.
//  - Latency: in_fire at edge N -> out_valid/out_data visible after edge N (1 cycle).
//  - Occupancy FSM (encoded by main_valid/skid_valid):
//    EMPTY: in_fire -> ONE (main<=in_data).
//    ONE:   in_fire&out_fire -> ONE (main<=in_data); in_fire&!out_fire -> FULL (skid<=in_data);
//           !in_fire&out_fire -> EMPTY; else hold.
//    FULL:  in_ready=0; out_fire -> ONE (main<=skid); else hold.
//  - Order preserved: skid entry always newer than main entry.
//  - flush=1: highest priority; next state EMPTY regardless of in_fire/out_fire; in_fire that cycle
//    is dropped (not counted); out_fire that cycle still completes downstream (not counted).
//    flush_cnt += number of entries held and not leaving via out_fire.
//  - stall_cnt += 1 each cycle out_valid & !out_ready & !flush; holds at 2^CNT_W-1.
//  - CLEAR_ON_BUBBLE=1: main_data written 0 on any transition into EMPTY (incl. flush), so
//    out_data=0 whenever out_valid=0 (a bubble never carries a stale RegWrite/MemWrite bit).
//  - CLEAR_ON_BUBBLE=0: data registers hold; only valid bits cleared.
//  - out_data/out_valid stable while out_valid & !out_ready (no change until out_fire or flush).
//  - in_ready depends only on state, never combinationally on out_ready.
//  - Reset mid-transfer: all entries lost immediately, counters cleared.
// STRUCTURE
//  - Package cpu_pipe_pkg: field widths/offsets for MEM/WB payload (MemtoReg, RegWrite,
//    MemWrite[1:0], MemRead[1:0], Aluout, pc, busB, rdata, rd) and WIDTH constant per stage.
//  - One sub-module: sat_counter (CNT_W, inc, value), instantiated twice.
//  - Occupancy logic and data registers stay in this module; no memories.
// TESTING
//  1 Reset: drive reset=0 mid-traffic -> out_valid=0, out_data=0, in_ready=1, counters=0 at once.
//  2 Streaming: out_ready=1, in_valid=1 for 100 cycles, data=i -> out_data=i one cycle later,
//    no bubbles, in_ready never 0, stall_cnt=0.
//  3 Back-pressure: send A,B,C with out_ready=0 -> A,B held, in_ready=0 after B, C stalled
//    upstream; release out_ready -> A,B,C in order, stall_cnt = stalled cycles.
//  4 Flush FULL: hold A,B, assert flush with in_valid=1 (C) -> EMPTY next cycle, C dropped,
//    flush_cnt=2, out_data=0 (CLEAR_ON_BUBBLE=1).
//  5 Flush with out_fire: ONE state, out_ready=1, flush=1 -> entry leaves, flush_cnt unchanged.
//  6 Saturation: CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt=15, then holds.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: MEM/WB and EX/MEM payload layouts, stage widths
// and the occupancy encoding used by the generic skid-buffered stage register.
package cpu_pipe_pkg;

  localparam int MEMTOREG_W = 1;
  localparam int REGWRITE_W = 1;
  localparam int MEMWRITE_W = 2;
  localparam int MEMREAD_W  = 2;
  localparam int ALUOUT_W   = 32;
  localparam int PC_W       = 32;
  localparam int BUSB_W     = 32;
  localparam int RDATA_W    = 32;
  localparam int RD_W       = 5;

  // Bit offsets of the MEM/WB fields inside the packed payload, LSB first.
  localparam int RD_LSB       = 0;
  localparam int RDATA_LSB    = RD_LSB + RD_W;
  localparam int BUSB_LSB     = RDATA_LSB + RDATA_W;
  localparam int PC_LSB       = BUSB_LSB + BUSB_W;
  localparam int ALUOUT_LSB   = PC_LSB + PC_W;
  localparam int MEMREAD_LSB  = ALUOUT_LSB + ALUOUT_W;
  localparam int MEMWRITE_LSB = MEMREAD_LSB + MEMREAD_W;
  localparam int REGWRITE_LSB = MEMWRITE_LSB + MEMWRITE_W;
  localparam int MEMTOREG_LSB = REGWRITE_LSB + REGWRITE_W;

  typedef struct packed {
    logic [MEMTOREG_W-1:0] mem_to_reg;
    logic [REGWRITE_W-1:0] reg_write;
    logic [MEMWRITE_W-1:0] mem_write;
    logic [MEMREAD_W-1:0]  mem_read;
    logic [ALUOUT_W-1:0]   alu_out;
    logic [PC_W-1:0]       pc;
    logic [BUSB_W-1:0]     bus_b;
    logic [RDATA_W-1:0]    rdata;
    logic [RD_W-1:0]       rd;
  } memwb_t;

  // EX/MEM carries the same control and address fields but no load data yet.
  typedef struct packed {
    logic [MEMTOREG_W-1:0] mem_to_reg;
    logic [REGWRITE_W-1:0] reg_write;
    logic [MEMWRITE_W-1:0] mem_write;
    logic [MEMREAD_W-1:0]  mem_read;
    logic [ALUOUT_W-1:0]   alu_out;
    logic [PC_W-1:0]       pc;
    logic [BUSB_W-1:0]     bus_b;
    logic [RD_W-1:0]       rd;
  } exmem_t;

  localparam int MEMWB_W     = $bits(memwb_t);
  localparam int EXMEM_W     = $bits(exmem_t);
  localparam int DEFAULT_W   = 72;
  localparam int DEFAULT_CNT = 16;

  // Bit 0 mirrors main_valid, bit 1 mirrors skid_valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b11
  } occ_e;

  function automatic logic [1:0] occ_count(input occ_e s);
    case (s)
      OCC_ONE:  return 2'd1;
      OCC_FULL: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a small per-cycle increment; sticks at all-ones
// instead of wrapping so profiling counts never read low after overflow.
module sat_counter #(
  parameter int CNT_W = 16,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W:0] sum;

  always_comb begin
    sum = {1'b0, value} + (CNT_W + 1)'(inc);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (sum[CNT_W]) begin
      value <= '1;
    end else begin
      value <= sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush, bubble zeroing and stall/flush profiling counters.
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_W,
  parameter bit CLEAR_ON_BUBBLE = 1'b1,
  parameter int CNT_W           = DEFAULT_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  occ_e             state, state_n;
  logic [WIDTH-1:0] main_data, main_data_n;
  logic [WIDTH-1:0] skid_data, skid_data_n;
  logic             main_valid, skid_valid;
  logic             in_fire, out_fire;
  logic [1:0]       flush_inc;
  logic [1:0]       stall_inc;
  logic [WIDTH-1:0] bubble_data;

  assign main_valid = state[0];
  assign skid_valid = state[1];

  // in_ready comes straight from a state bit so there is no combinational
  // path from out_ready back to upstream.
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign bubble_data = CLEAR_ON_BUBBLE ? '0 : main_data;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    main_data_n = main_data;
    skid_data_n = skid_data;
    flush_inc   = 2'd0;

    if (flush) begin
      // Whatever is held and not leaving downstream this cycle is discarded.
      state_n     = OCC_EMPTY;
      main_data_n = bubble_data;
      flush_inc   = occ_count(state) - {1'b0, out_fire};
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (in_fire) begin
            state_n     = OCC_ONE;
            main_data_n = in_data;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_data_n = in_data;
          end else if (in_fire) begin
            state_n     = OCC_FULL;
            skid_data_n = in_data;
          end else if (out_fire) begin
            state_n     = OCC_EMPTY;
            main_data_n = bubble_data;
          end
        end
        OCC_FULL: begin
          // Skid always holds the newer entry, so it moves up into main.
          if (out_fire) begin
            state_n     = OCC_ONE;
            main_data_n = skid_data;
          end
        end
        default: begin
          state_n     = OCC_EMPTY;
          main_data_n = bubble_data;
        end
      endcase
    end
  end

  // NOTE: data registers are reset too, so out_data reads 0 straight out of
  // reset instead of whatever the flops powered up with.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= OCC_EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_n;
      main_data <= main_data_n;
      skid_data <= skid_data_n;
    end
  end

  assign stall_inc = {1'b0, out_valid & ~out_ready & ~flush};

  sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (2)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .value (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W),
    .INC_W (2)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .value (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure, flush
// and counter saturation, with hand-computed expected values.
module tb_pipe_stage_skid;

  localparam int W = 72;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [15:0]  stall_cnt, flush_cnt;

  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [3:0]   s_stall_cnt, s_flush_cnt;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [W-1:0] A = 72'hA1_0000_0000_0000_00AA;
  localparam logic [W-1:0] B = 72'hB2_1111_2222_3333_44BB;
  localparam logic [W-1:0] C = 72'hC3_5555_6666_7777_88CC;
  localparam logic [W-1:0] D = 72'hD4_DEAD_BEEF_0000_00DD;
  localparam logic [W-1:0] E = 72'hE5_CAFE_F00D_1234_56EE;
  localparam logic [W-1:0] F = 72'hF6_0F0F_0F0F_0F0F_0FFF;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(W), .CLEAR_ON_BUBBLE(1'b1), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  // Narrow-counter copy sharing all stimulus; only checked for saturation.
  pipe_stage_skid #(.WIDTH(W), .CLEAR_ON_BUBBLE(1'b1), .CNT_W(4)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (s_in_ready),
    .out_valid (s_out_valid),
    .out_data  (s_out_data),
    .out_ready (out_ready),
    .stall_cnt (s_stall_cnt),
    .flush_cnt (s_flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] observed,
                       input logic [W-1:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, W'(out_valid), W'(1'b0));
    check({tag, ".out_data"},  out_data,      '0);
    check({tag, ".in_ready"},  W'(in_ready),  W'(1'b1));
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();

    check_idle("por");
    check("por.stall_cnt", W'(stall_cnt), '0);
    check("por.flush_cnt", W'(flush_cnt), '0);
    reset = 1'b1;
    tick();

    // Streaming: one transfer per cycle, each word visible one edge later.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = W'(i + 1);
      tick();
      check("stream.out_valid", W'(out_valid), W'(1'b1));
      check("stream.out_data",  out_data,      W'(i + 1));
      check("stream.in_ready",  W'(in_ready),  W'(1'b1));
    end
    in_valid = 1'b0;
    tick();
    check_idle("stream_drain");
    check("stream.stall_cnt", W'(stall_cnt), '0);

    // Back-pressure: A,B fill the stage, C waits upstream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A;
    tick();
    check("bp.one.out_data",  out_data,     A);
    check("bp.one.in_ready",  W'(in_ready), W'(1'b1));
    check("bp.one.stall_cnt", W'(stall_cnt), W'(0));
    in_data = B;
    tick();
    check("bp.full.out_data",  out_data,      A);
    check("bp.full.in_ready",  W'(in_ready),  W'(1'b0));
    check("bp.full.stall_cnt", W'(stall_cnt), W'(1));
    in_data = C;
    tick();
    tick();
    check("bp.hold.out_valid", W'(out_valid), W'(1'b1));
    check("bp.hold.out_data",  out_data,      A);
    check("bp.hold.stall_cnt", W'(stall_cnt), W'(3));
    out_ready = 1'b1;
    tick();
    check("bp.rel1.out_data",  out_data,      B);
    check("bp.rel1.in_ready",  W'(in_ready),  W'(1'b1));
    check("bp.rel1.stall_cnt", W'(stall_cnt), W'(3));
    tick();
    check("bp.rel2.out_data",  out_data,      C);
    in_valid = 1'b0;
    tick();
    check_idle("bp_drain");
    check("bp.stall_final", W'(stall_cnt), W'(3));

    // Reset mid-transfer with both entries held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = D;
    tick();
    in_data = E;
    tick();
    check("rst.pre.stall_cnt", W'(stall_cnt), W'(4));
    check("rst.pre.in_ready",  W'(in_ready),  W'(1'b0));
    reset = 1'b0;
    #1;
    check_idle("rst_async");
    check("rst.stall_cnt", W'(stall_cnt), '0);
    tick();
    tick();
    check_idle("rst_ignores_in_valid");
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();

    // Flush while FULL: both entries discarded, incoming C dropped.
    in_valid = 1'b1;
    in_data  = A;
    tick();
    in_data = B;
    tick();
    check("fl.pre.in_ready", W'(in_ready), W'(1'b0));
    flush   = 1'b1;
    in_data = C;
    tick();
    check_idle("flush_full");
    check("fl.flush_cnt", W'(flush_cnt), W'(2));
    check("fl.stall_cnt", W'(stall_cnt), W'(1));
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check_idle("flush_c_dropped");

    // Flush coinciding with out_fire: the leaving entry is not counted.
    in_valid = 1'b1;
    in_data  = F;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    check("flo.out_valid", W'(out_valid), W'(1'b1));
    check("flo.out_data",  out_data,      F);
    tick();
    check_idle("flush_outfire");
    check("flo.flush_cnt", W'(flush_cnt), W'(2));
    // Flush in ONE without out_fire counts the single entry.
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = E;
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    check("flone.flush_cnt", W'(flush_cnt), W'(3));
    check_idle("flush_one");
    flush = 1'b0;

    // Saturation: 4-bit counter stops at 15, 16-bit keeps counting.
    reset = 1'b0;
    tick();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = D;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 14) check("sat.k14", W'(s_stall_cnt), W'(14));
      if (k == 15) check("sat.k15", W'(s_stall_cnt), W'(15));
      if (k == 20) begin
        check("sat.k20",      W'(s_stall_cnt), W'(15));
        check("sat.wide.k20", W'(stall_cnt),   W'(20));
      end
    end
    check("sat.hold",      W'(s_stall_cnt), W'(15));
    check("sat.wide.k25",  W'(stall_cnt),   W'(25));
    check("sat.out_data",  s_out_data,      D);
    check("sat.flush_cnt", W'(s_flush_cnt), '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
